// File: rtl/mc_cpu_pkg.sv
// mc_cpu_pkg: shared definitions for the multi-cycle RV32I-subset core.
//   - opcode / funct3 / funct7 constants for the supported instructions
//   - control FSM state enum, ALU operation enum, immediate format enum
//   - imm_gen(): sign-extended immediate extraction for I/S/B formats
package mc_cpu_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_SLT = 3'd4
  } alu_op_t;

  typedef enum logic [1:0] {
    IMM_I = 2'd0,
    IMM_S = 2'd1,
    IMM_B = 2'd2
  } imm_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] ins, input imm_t t);
    logic [31:0] v;
    unique case (t)
      IMM_S:   v = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B:   v = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      default: v = {{20{ins[31]}}, ins[31:20]};
    endcase
    return v;
  endfunction

endpackage

// File: rtl/mc_cpu_core_alu.sv
// mc_alu: combinational ALU for the multi-cycle core.
// Ports:
//   i_a, i_b [31:0]  operands
//   i_op             alu_op_t (add, sub, and, or, signed slt)
//   o_y  [31:0]      result (add/sub wrap modulo 2^32)
//   o_zero           o_y == 0 (used for beq with ALU_SUB)
module mc_alu
  import mc_cpu_pkg::*;
(
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  alu_op_t     i_op,
  output logic [31:0] o_y,
  output logic        o_zero
);

  always_comb begin
    o_y = '0;
    unique case (i_op)
      ALU_ADD: o_y = i_a + i_b;
      ALU_SUB: o_y = i_a - i_b;
      ALU_AND: o_y = i_a & i_b;
      ALU_OR:  o_y = i_a | i_b;
      ALU_SLT: o_y = {31'd0, $signed(i_a) < $signed(i_b)};
      default: o_y = '0;
    endcase
  end

  assign o_zero = (o_y == 32'd0);

endmodule

// File: rtl/mc_cpu_core.sv
// mc_cpu_core: multi-cycle RV32I-subset core with a single shared memory port.
// Parameters: NREGS (8/16/32), ADDR_W (8..32), RESET_PC (word aligned).
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   step                  single-step advance (only with MC_CPU_STEP_EN)
//   mem_req/we/addr/wdata request to unified memory, held until mem_ready
//   mem_rdata, mem_ready  read data and transfer completion
//   pc, instr             current instruction address and latched instruction
//   retire                one-cycle pulse, coincident with the pc update
//   halted, illegal       sticky stop and its cause (unsupported encoding)
// Optional build macro: MC_CPU_STEP_EN (fetch waits for step=1).
//
// state    | meaning
// FETCH    | request instruction at pc, latch it on mem_ready
// DECODE   | read rs1/rs2, build immediate, trap illegal encodings
// EXEC     | ALU; beq resolves and retires, lw/sw issue data request
// MEM      | wait for data transfer; sw retires, lw latches data
// WB       | write rd, retire
// HALT     | stopped until reset
module mc_cpu_core
  import mc_cpu_pkg::*;
#(
  parameter int                NREGS    = 32,
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              step,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instr,
  output logic              retire,
  output logic              halted,
  output logic              illegal
);

  localparam int         RIDX_W  = $clog2(NREGS);
  localparam logic [5:0] NREGS_L = 6'(NREGS);

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_instr;
  logic [31:0]         r_a, r_b, r_imm, r_res;
  alu_op_t             r_alu_op;
  logic                r_use_imm;
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_retire, r_halted, r_illegal;
  logic [31:0]         r_regs [NREGS];

  logic [6:0]          w_opcode, w_f7;
  logic [2:0]          w_f3;
  logic [4:0]          w_rd, w_rs1, w_rs2;
  logic                w_rd_ok, w_rs1_ok, w_rs2_ok;
  logic                w_legal, w_use_imm;
  alu_op_t             w_alu_op;
  imm_t                w_imm_type;
  logic [31:0]         w_rs1_val, w_rs2_val;
  logic [31:0]         w_alu_b, w_alu_y;
  logic                w_alu_zero;
  logic                w_is_beq, w_is_mem, w_is_store;
  logic [ADDR_W-1:0]   w_pc_inc, w_pc_br, w_pc_nxt;
  logic                w_retire, w_step_ok, w_issue_fetch;

`ifdef MC_CPU_STEP_EN
  assign w_step_ok = step;
`else
  logic w_unused_step;
  assign w_unused_step = step;
  assign w_step_ok     = 1'b1;
`endif

  assign w_opcode = r_instr[6:0];
  assign w_rd     = r_instr[11:7];
  assign w_f3     = r_instr[14:12];
  assign w_rs1    = r_instr[19:15];
  assign w_rs2    = r_instr[24:20];
  assign w_f7     = r_instr[31:25];

  assign w_rd_ok  = ({1'b0, w_rd}  < NREGS_L);
  assign w_rs1_ok = ({1'b0, w_rs1} < NREGS_L);
  assign w_rs2_ok = ({1'b0, w_rs2} < NREGS_L);

  assign w_rs1_val = (w_rs1 == 5'd0) ? 32'd0 : r_regs[w_rs1[RIDX_W-1:0]];
  assign w_rs2_val = (w_rs2 == 5'd0) ? 32'd0 : r_regs[w_rs2[RIDX_W-1:0]];

  assign w_is_beq   = (w_opcode == OP_BRANCH);
  assign w_is_store = (w_opcode == OP_STORE);
  assign w_is_mem   = (w_opcode == OP_LOAD) || w_is_store;

  always_comb begin
    w_legal    = 1'b0;
    w_alu_op   = ALU_ADD;
    w_use_imm  = 1'b0;
    w_imm_type = IMM_I;
    unique case (w_opcode)
      OP_R: begin
        if (w_f7 == F7_BASE) begin
          unique case (w_f3)
            F3_ADD:  begin w_legal = 1'b1; w_alu_op = ALU_ADD; end
            F3_AND:  begin w_legal = 1'b1; w_alu_op = ALU_AND; end
            F3_OR:   begin w_legal = 1'b1; w_alu_op = ALU_OR;  end
            F3_SLT:  begin w_legal = 1'b1; w_alu_op = ALU_SLT; end
            default: w_legal = 1'b0;
          endcase
        end else if (w_f7 == F7_SUB && w_f3 == F3_ADD) begin
          w_legal  = 1'b1;
          w_alu_op = ALU_SUB;
        end
        w_legal = w_legal && w_rd_ok && w_rs1_ok && w_rs2_ok;
      end
      OP_IMM: begin
        w_legal   = (w_f3 == F3_ADD) && w_rd_ok && w_rs1_ok;
        w_use_imm = 1'b1;
      end
      OP_LOAD: begin
        w_legal   = (w_f3 == F3_W) && w_rd_ok && w_rs1_ok;
        w_use_imm = 1'b1;
      end
      OP_STORE: begin
        w_legal    = (w_f3 == F3_W) && w_rs1_ok && w_rs2_ok;
        w_use_imm  = 1'b1;
        w_imm_type = IMM_S;
      end
      OP_BRANCH: begin
        w_legal    = (w_f3 == F3_BEQ) && w_rs1_ok && w_rs2_ok;
        w_alu_op   = ALU_SUB;
        w_imm_type = IMM_B;
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_alu_b = r_use_imm ? r_imm : r_b;

  mc_alu u_alu (
    .i_a    (r_a),
    .i_b    (w_alu_b),
    .i_op   (r_alu_op),
    .o_y    (w_alu_y),
    .o_zero (w_alu_zero)
  );

  assign w_pc_inc = r_pc + ADDR_W'(4);
  assign w_pc_br  = r_pc + r_imm[ADDR_W-1:0];

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_retire    = 1'b0;
    unique case (r_state)
      S_FETCH:  if (r_mem_req && mem_ready) w_state_nxt = S_DECODE;
      S_DECODE: w_state_nxt = w_legal ? S_EXEC : S_HALT;
      S_EXEC: begin
        if (w_is_beq) begin
          w_retire    = 1'b1;
          w_pc_nxt    = w_alu_zero ? w_pc_br : w_pc_inc;
          w_state_nxt = S_FETCH;
        end else if (w_is_mem) begin
          w_state_nxt = S_MEM;
        end else begin
          w_state_nxt = S_WB;
        end
      end
      S_MEM: begin
        if (r_mem_req && mem_ready) begin
          if (r_mem_we) begin
            w_retire    = 1'b1;
            w_pc_nxt    = w_pc_inc;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end
      end
      S_WB: begin
        w_retire    = 1'b1;
        w_pc_nxt    = w_pc_inc;
        w_state_nxt = S_FETCH;
      end
      S_HALT:  w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // Launch the next fetch on the same edge that enters FETCH so no idle cycle
  // is spent there; an idle FETCH cycle only occurs after reset or while
  // waiting for step.
  assign w_issue_fetch = (w_state_nxt == S_FETCH) && w_step_ok &&
                         !(r_state == S_FETCH && r_mem_req);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc        <= RESET_PC;
      r_instr     <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_imm       <= '0;
      r_res       <= '0;
      r_alu_op    <= ALU_ADD;
      r_use_imm   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= RESET_PC;
      r_mem_wdata <= '0;
      r_retire    <= 1'b0;
      r_halted    <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_retire <= w_retire;
      if (w_retire) r_pc <= w_pc_nxt;
      unique case (r_state)
        S_FETCH: begin
          if (r_mem_req && mem_ready) begin
            r_instr   <= mem_rdata;
            r_mem_req <= 1'b0;
          end
        end
        S_DECODE: begin
          r_a       <= w_rs1_val;
          r_b       <= w_rs2_val;
          r_imm     <= imm_gen(r_instr, w_imm_type);
          r_alu_op  <= w_alu_op;
          r_use_imm <= w_use_imm;
          if (!w_legal) begin
            r_halted  <= 1'b1;
            r_illegal <= 1'b1;
          end
        end
        S_EXEC: begin
          r_res <= w_alu_y;
          if (w_is_mem) begin
            r_mem_req   <= 1'b1;
            r_mem_we    <= w_is_store;
            r_mem_addr  <= w_alu_y[ADDR_W-1:0];
            r_mem_wdata <= r_b;
          end
        end
        S_MEM: begin
          if (r_mem_req && mem_ready) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            if (!r_mem_we) r_res <= mem_rdata;
          end
        end
        default: ;
      endcase
      if (w_issue_fetch) begin
        r_mem_req  <= 1'b1;
        r_mem_we   <= 1'b0;
        r_mem_addr <= w_pc_nxt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else if (r_state == S_WB && w_rd != 5'd0) begin
      r_regs[w_rd[RIDX_W-1:0]] <= r_res;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign pc        = r_pc;
  assign instr     = r_instr;
  assign retire    = r_retire;
  assign halted    = r_halted;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_mc_cpu_core.sv
module tb_mc_cpu_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        step = 1'b0;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic [31:0] pc, instr;
  logic        retire, halted, illegal;

  int checks = 0;
  int errors = 0;

  mc_cpu_core #(.NREGS(16), .ADDR_W(32), .RESET_PC(32'h40)) dut (
    .clk(clk), .reset(reset), .step(step),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .pc(pc), .instr(instr), .retire(retire), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // memory responder: addresses below 0x40 are data with data_wait wait cycles
  logic [31:0] mem [256];
  int  cnt = 0;
  int  data_wait = 2;
  bit  done = 1'b0;
  bit  stall = 1'b0;
  int  st_cnt = 0;
  logic [31:0] st_addr = '0, st_data = '0;

  always @(posedge clk) begin
    if (mem_req && mem_ready) begin
      if (mem_we) begin
        mem[mem_addr[9:2]] = mem_wdata;
        st_cnt++;
        st_addr = mem_addr;
        st_data = mem_wdata;
      end
      done = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (done || !mem_req) begin
      cnt  = 0;
      done = 1'b0;
    end
    mem_ready = 1'b0;
    if (mem_req && !stall) begin
      if (cnt >= ((mem_addr < 32'h40) ? data_wait : 0)) begin
        mem_ready = 1'b1;
        mem_rdata = mem[mem_addr[9:2]];
      end else begin
        cnt++;
      end
    end
  end

  int cyc = 0;
  int ret_cyc[$];
  logic [31:0] ret_pc[$];
  int halt_req = 0;

  always @(negedge clk) begin
    cyc++;
    if (retire) begin
      ret_cyc.push_back(cyc);
      ret_pc.push_back(pc);
    end
    if (halted && mem_req) halt_req++;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag, input int lim);
    int n = 0;
    while (!mem_req && n < lim) begin tick(); n++; end
    chk(tag, 32'(mem_req), 32'd1);
  endtask

  task automatic wait_halt(input string tag, input int lim);
    int n = 0;
    while (!halted && n < lim) begin tick(); n++; end
    chk(tag, 32'(halted), 32'd1);
  endtask

  task automatic load_main();
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 32'h00500093; // 40 addi x1,x0,5
    mem[17] = 32'hFFD00113; // 44 addi x2,x0,-3
    mem[18] = 32'h002081B3; // 48 add  x3,x1,x2
    mem[19] = 32'h00112233; // 4C slt  x4,x2,x1
    mem[20] = 32'h00102423; // 50 sw   x1,8(x0)
    mem[21] = 32'h00802283; // 54 lw   x5,8(x0)
    mem[22] = 32'h40110333; // 58 sub  x6,x2,x1
    mem[23] = 32'h0020E433; // 5C or   x8,x1,x2
    mem[24] = 32'h00008463; // 60 beq  x1,x0,+8  (not taken)
    mem[25] = 32'h00000663; // 64 beq  x0,x0,+12 -> 70
    mem[26] = 32'h0020F3B3; // 68 and  x7,x1,x2
    mem[27] = 32'h0000007F; // 6C illegal opcode
    mem[28] = 32'hFE000CE3; // 70 beq  x0,x0,-8  -> 68
  endtask

  int          exp_int [11] = '{4, 4, 4, 6, 7, 4, 4, 3, 3, 3, 4};
  logic [31:0] exp_pc  [12] = '{32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58,
                                32'h5C, 32'h60, 32'h64, 32'h70, 32'h68, 32'h6C};

  initial begin
    load_main();
    repeat (3) tick();
    chk("rst_pc",      pc,              32'h40);
    chk("rst_instr",   instr,           32'h0);
    chk("rst_req",     32'(mem_req),    32'd0);
    chk("rst_we",      32'(mem_we),     32'd0);
    chk("rst_addr",    mem_addr,        32'h40);
    chk("rst_wdata",   mem_wdata,       32'h0);
    chk("rst_retire",  32'(retire),     32'd0);
    chk("rst_halted",  32'(halted),     32'd0);
    chk("rst_illegal", 32'(illegal),    32'd0);

    ret_cyc.delete();
    ret_pc.delete();
    reset = 1'b0;
`ifdef MC_CPU_STEP_EN
    repeat (5) tick();
    chk("step_low_no_fetch", 32'(mem_req), 32'd0);
    step = 1'b1;
`endif
    wait_req("first_req", 10);
    chk("first_addr", mem_addr, 32'h40);
    chk("first_we",   32'(mem_we), 32'd0);

    wait_halt("prog_halt", 400);
    chk("retire_count", 32'(ret_cyc.size()), 32'd12);
    if (ret_cyc.size() == 12) begin
      for (int i = 0; i < 11; i++)
        chk($sformatf("interval%0d", i), 32'(ret_cyc[i+1] - ret_cyc[i]), 32'(exp_int[i]));
      for (int i = 0; i < 12; i++)
        chk($sformatf("retire_pc%0d", i), ret_pc[i], exp_pc[i]);
    end
    chk("x1", dut.r_regs[1], 32'h5);
    chk("x2", dut.r_regs[2], 32'hFFFFFFFD);
    chk("x3_add", dut.r_regs[3], 32'h2);
    chk("x4_slt", dut.r_regs[4], 32'h1);
    chk("x5_lw",  dut.r_regs[5], 32'h5);
    chk("x6_sub", dut.r_regs[6], 32'hFFFFFFF8);
    chk("x7_and", dut.r_regs[7], 32'h5);
    chk("x8_or",  dut.r_regs[8], 32'hFFFFFFFD);
    chk("store_count", 32'(st_cnt), 32'd1);
    chk("store_addr",  st_addr, 32'h8);
    chk("store_data",  st_data, 32'h5);
    chk("mem8",        mem[2],  32'h5);
    chk("halt_illegal", 32'(illegal), 32'd1);
    chk("halt_instr",   instr, 32'h7F);
    chk("halt_pc",      pc, 32'h6C);
    repeat (10) tick();
    chk("halt_no_req",  32'(halt_req), 32'd0);
    chk("halt_sticky",  32'(halted), 32'd1);

    reset = 1'b1;
    tick();
    chk("rst_clr_halted",  32'(halted), 32'd0);
    chk("rst_clr_illegal", 32'(illegal), 32'd0);

    // rd index beyond NREGS=16
    for (int i = 0; i < 256; i++) mem[i] = '0;
    mem[16] = 32'h00100A13; // addi x20,x0,1
    ret_cyc.delete();
    halt_req = 0;
    tick();
    reset = 1'b0;
    wait_halt("reg_halt", 50);
    chk("reg_illegal", 32'(illegal), 32'd1);
    chk("reg_pc",      pc, 32'h40);
    repeat (10) tick();
    chk("reg_no_req",    32'(halt_req), 32'd0);
    chk("reg_no_retire", 32'(ret_cyc.size()), 32'd0);

    // reset while a fetch is waiting
    reset = 1'b1;
    load_main();
    ret_cyc.delete();
    ret_pc.delete();
    repeat (2) tick();
    reset = 1'b0;
    begin
      int n = 0;
      while (ret_cyc.size() < 2 && n < 50) begin tick(); n++; end
    end
    chk("pre_stall_retires", 32'(ret_cyc.size()), 32'd2);
    stall = 1'b1;
    begin
      int n = 0;
      while (!(mem_req && !mem_ready) && n < 30) begin tick(); n++; end
    end
    repeat (2) tick();
    chk("stall_req",  32'(mem_req), 32'd1);
    chk("stall_addr", mem_addr, 32'h4C);
    reset = 1'b1;
    tick();
    chk("abandon_req",  32'(mem_req), 32'd0);
    chk("abandon_pc",   pc, 32'h40);
    chk("abandon_addr", mem_addr, 32'h40);
    stall = 1'b0;
    reset = 1'b0;
    wait_req("restart_req", 10);
    chk("restart_addr", mem_addr, 32'h40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
